// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants and FSM encoding for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  // Transmitter states; encodings are fixed so they can be probed externally.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 8N1: one start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  // Stored word layout: [7:0] payload, [8] end-of-message flag.
  localparam int FLAG_BIT = 8;
  localparam int WORD_W   = FLAG_BIT + 1;

endpackage

// File: rtl/fifo_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and combinational head.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_ptr_q];

  // Guard requests so a misbehaving caller can never corrupt the count.
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; storage contents need no reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Write-only Wishbone sink that buffers 9-bit words and sends them as 8N1 UART.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 139
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WORD_W-1:0] i_wb_dat,
  input  logic              i_wb_we,
  input  logic              i_wb_stb,
  output logic              o_wb_ack,
  output logic              o_tx,
  output logic              o_msg_done,
  output logic              o_empty
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  last_q, last_d;
  logic                  tx_q, tx_d;
  logic                  ack_q, ack_d;
  logic                  done_pend_q, done_pend_d;
  logic                  msg_done_q, msg_done_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]     fifo_head;
  logic                  baud_end;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_din   (i_wb_dat),
    .i_pop   (fifo_pop),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

  // Bus side: writes push when there is room, reads are acked and dropped;
  // a held strobe is never re-accepted in the ack cycle.
  always_comb begin
    fifo_push = i_wb_stb & i_wb_we & ~fifo_full & ~ack_q;
    ack_d     = fifo_push | (i_wb_stb & ~i_wb_we & ~ack_q);
  end

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Transmitter next-state logic; the line level is derived from the current
  // state so the registered output trails the state by one clock.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    fifo_pop    = 1'b0;
    done_pend_d = 1'b0;
    tx_d        = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head[DATA_BITS-1:0];
          last_d   = fifo_head[FLAG_BIT];
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d      = '0;
          done_pend_d = last_q;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            fifo_pop = 1'b1;
            shift_d  = fifo_head[DATA_BITS-1:0];
            last_d   = fifo_head[FLAG_BIT];
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Delay the end-of-message pulse to line up with the line's stop bit end.
    msg_done_d = done_pend_q;
  end

  // State register; reset forces the line high immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      tx_q        <= 1'b1;
      ack_q       <= 1'b0;
      done_pend_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      ack_q       <= ack_d;
      done_pend_q <= done_pend_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_tx       = tx_q;
  assign o_msg_done = msg_done_q;
  assign o_empty    = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a UART line decoder.
module tb_fifo_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] dat = '0;
  logic       we = 1'b0;
  logic       stb = 1'b0;
  logic       ack, tx, done, empty;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  fifo_uart_tx #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wb_dat   (dat),
    .i_wb_we    (we),
    .i_wb_stb   (stb),
    .o_wb_ack   (ack),
    .o_tx       (tx),
    .o_msg_done (done),
    .o_empty    (empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART line decoder: samples mid-bit on falling clock edges.
  logic       mon_en = 1'b1;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin : frame
        int         sc;
        logic [7:0] b;
        logic       ok;
        sc = cyc;
        ok = 1'b1;
        b  = '0;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (mon_en) begin
          if (ok) begin
            rx_q.push_back(b);
            start_q.push_back(sc);
          end else begin
            frame_err++;
          end
        end
      end
    end
  end

  // End-of-message pulse recorder.
  int done_cnt = 0;
  int done_cyc = -1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [8:0] d, output int acc_cyc);
    int w;
    w = 0;
    acc_cyc = -1;
    stb = 1'b1;
    we  = 1'b1;
    dat = d;
    while (w < 40 * CPB) begin
      @(posedge clk);
      #1;
      w++;
      if (ack === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
    end
    stb = 1'b0;
    we  = 1'b0;
    if (acc_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wb_write_ack_timeout data=%h got no ack want ack", d);
    end else begin
      $display("write data=%h acked at cycle %0d", d, acc_cyc);
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (empty !== 1'b1 && w < 60 * FRAME) begin
      step(1);
      w++;
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_idle_timeout got empty=%b want 1", tag, empty);
    end
    step(2 * CPB);
  endtask

  task automatic test_reset;
    step(3);
    n_cmp += 4;
    if (ack !== 1'b0)   begin n_bad++; $display("FAIL rst_ack got %b want 0", ack); end
    if (tx !== 1'b1)    begin n_bad++; $display("FAIL rst_tx got %b want 1", tx); end
    if (done !== 1'b0)  begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", empty); end
    rst_n = 1'b1;
    step(2);
    n_cmp += 2;
    if (tx !== 1'b1)    begin n_bad++; $display("FAIL post_rst_tx got %b want 1", tx); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL post_rst_empty got %b want 1", empty); end
  endtask

  task automatic test_single;
    int         n, d0;
    logic [9:0] pat;
    pat = 10'b1010101010;
    rx_q.delete(); start_q.delete();
    d0 = done_cnt;
    wb_write(9'h155, n);
    n_cmp++;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL single_ack got %b want 1", ack); end
    step(1);
    n_cmp += 2;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_width got %b want 0", ack); end
    if (tx !== 1'b1)  begin n_bad++; $display("FAIL single_pre_start got tx=%b want 1", tx); end
    step(1);
    n_cmp++;
    if (tx !== 1'b0) begin n_bad++; $display("FAIL single_start_edge got tx=%b want 0", tx); end
    for (int k = 0; k < 10; k++) begin
      step(k == 0 ? CPB / 2 : CPB);
      n_cmp++;
      if (tx !== pat[k]) begin
        n_bad++; $display("FAIL single_bit%0d got tx=%b want %b", k, tx, pat[k]);
      end
    end
    step(CPB);
    n_cmp += 4;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
    if (done_cyc != n + 2 + FRAME) begin
      n_bad++; $display("FAIL single_done_time got %0d want %0d", done_cyc, n + 2 + FRAME);
    end
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_bad++; $display("FAIL single_rx got size=%0d want 1 byte 55", rx_q.size());
    end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty got %b want 1", empty); end
  endtask

  task automatic test_backpressure;
    int acc[DEPTH + 2];
    int d0;
    rx_q.delete(); start_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < DEPTH + 2; i++) wb_write(9'(8'hA0 + i), acc[i]);
    for (int i = 1; i <= DEPTH; i++) begin
      n_cmp++;
      if (acc[i] - acc[i-1] != 2) begin
        n_bad++; $display("FAIL bp_ack_spacing%0d got %0d want 2", i, acc[i] - acc[i-1]);
      end
    end
    n_cmp++;
    if (acc[DEPTH+1] != acc[0] + 2 + FRAME) begin
      n_bad++; $display("FAIL bp_withheld_ack got %0d want %0d", acc[DEPTH+1], acc[0] + 2 + FRAME);
    end
    wait_idle("bp");
    n_cmp += 2;
    if (rx_q.size() != DEPTH + 2) begin
      n_bad++; $display("FAIL bp_rx_count got %0d want %0d", rx_q.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        n_cmp++;
        if (rx_q[i] !== 8'(8'hA0 + i)) begin
          n_bad++; $display("FAIL bp_rx%0d got %h want %h", i, rx_q[i], 8'(8'hA0 + i));
        end
      end
    end
    if (done_cnt != d0) begin n_bad++; $display("FAIL bp_no_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int a, b, d0;
    rx_q.delete(); start_q.delete();
    d0 = done_cnt;
    wb_write(9'h041, a);
    wb_write(9'h142, b);
    wait_idle("b2b");
    n_cmp += 3;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42) begin
      n_bad++; $display("FAIL b2b_rx got size=%0d want bytes 41 42", rx_q.size());
    end
    if (start_q.size() != 2 || start_q[1] - start_q[0] != FRAME) begin
      n_bad++; $display("FAIL b2b_gap got %0d starts want spacing %0d", start_q.size(), FRAME);
    end
    if (done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0);
    end else begin
      n_cmp++;
      if (start_q.size() == 2 && done_cyc != start_q[1] + FRAME) begin
        n_bad++; $display("FAIL b2b_done_time got %0d want %0d", done_cyc, start_q[1] + FRAME);
      end
    end
  endtask

  task automatic test_read;
    rx_q.delete(); start_q.delete();
    stb = 1'b1; we = 1'b0; dat = 9'h1FF;
    step(1);
    n_cmp++;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack got %b want 1", ack); end
    step(1);
    n_cmp++;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_drop got %b want 0", ack); end
    step(1);
    n_cmp++;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack_again got %b want 1", ack); end
    stb = 1'b0;
    $display("read strobe acked at cycle %0d", cyc);
    step(1);
    n_cmp += 3;
    if (ack !== 1'b0)   begin n_bad++; $display("FAIL rd_ack_end got %b want 0", ack); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL rd_empty got %b want 1", empty); end
    if (tx !== 1'b1)    begin n_bad++; $display("FAIL rd_tx got %b want 1", tx); end
    step(FRAME + CPB);
    n_cmp += 2;
    if (rx_q.size() != 0) begin n_bad++; $display("FAIL rd_no_frame got %0d want 0", rx_q.size()); end
    if (empty !== 1'b1)   begin n_bad++; $display("FAIL rd_empty_late got %b want 1", empty); end
  endtask

  task automatic test_reset_mid;
    int a, b, d0;
    rx_q.delete(); start_q.delete();
    wb_write(9'h0F0, a);
    wb_write(9'h1AA, b);
    // Now at cycle a+2, which is the line's start-bit edge; move to mid DATA bit 3.
    step(4 * CPB + CPB / 2);
    n_cmp++;
    if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_bit3 got tx=%b want 0", tx); end
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (tx !== 1'b1)    begin n_bad++; $display("FAIL mid_rst_tx got %b want 1", tx); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty got %b want 1", empty); end
    step(4);
    rst_n = 1'b1;
    step(2);
    n_cmp += 2;
    if (tx !== 1'b1)    begin n_bad++; $display("FAIL mid_rel_tx got %b want 1", tx); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_rel_empty got %b want 1", empty); end
    step(FRAME);
    n_cmp++;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_discard got empty=%b want 1", empty); end
    rx_q.delete(); start_q.delete();
    mon_en = 1'b1;
    d0 = done_cnt;
    wb_write(9'h13C, a);
    wait_idle("mid");
    n_cmp += 2;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      n_bad++; $display("FAIL mid_after_rx got size=%0d want 1 byte 3c", rx_q.size());
    end
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL mid_after_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_wrap;
    int a, d0, e0;
    rx_q.delete(); start_q.delete();
    d0 = done_cnt;
    e0 = frame_err;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int g;
      wb_write(9'(i), a);
      g = $urandom_range(0, 3);
      if (g > 0) step(g);
    end
    wait_idle("wrap");
    n_cmp += 3;
    if (rx_q.size() != 3 * DEPTH) begin
      n_bad++; $display("FAIL wrap_rx_count got %0d want %0d", rx_q.size(), 3 * DEPTH);
    end else begin
      for (int i = 0; i < 3 * DEPTH; i++) begin
        n_cmp++;
        if (rx_q[i] !== 8'(i)) begin
          n_bad++; $display("FAIL wrap_rx%0d got %h want %h", i, rx_q[i], 8'(i));
        end
      end
    end
    if (done_cnt != d0)  begin n_bad++; $display("FAIL wrap_no_done got %0d want 0", done_cnt - d0); end
    if (frame_err != e0) begin n_bad++; $display("FAIL wrap_framing got %0d want 0", frame_err - e0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_read;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Write-only Wishbone sink for the CPU mux's FIFO window (address space `2'b11`). It buffers 9-bit words and serialises the low 8 bits on a UART line, 8N1 format, LSB first. Bit 8 of each word is an end-of-message flag, and the block pulses `o_msg_done` once that byte has fully left the wire. Backpressure is applied to the CPU by withholding `o_wb_ack` while the buffer is full.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Power of two, ≥2.
- `CLKS_PER_BIT`, 139: clock cycles per UART bit (16 MHz / 115200). ≥2.

Ports:
- `i_clk` in 1: single clock; all logic on rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_wb_dat` in 9: [7:0] payload, [8] end-of-message flag.
- `i_wb_we` in 1: write enable.
- `i_wb_stb` in 1: cycle strobe (already qualified with cyc and address decode upstream).
- `o_wb_ack` out 1: one-cycle transfer acknowledge.
- `o_tx` out 1: UART line, idle high.
- `o_msg_done` out 1: one-cycle pulse at the end of a flagged byte's stop bit.
- `o_empty` out 1: FIFO empty and transmitter idle.

## Operation
**Reset values:** `o_wb_ack=0`, `o_tx=1`, `o_msg_done=0`, `o_empty=1`, FIFO empty, state IDLE.

**Write path:**
- A write is accepted when `i_wb_stb & i_wb_we & !full & !o_wb_ack`.
- On that edge the word is pushed and `o_wb_ack` goes high for exactly one cycle.
- If `i_wb_stb & !i_wb_we` (a read), the block acks the next cycle and ignores the data. Nothing is pushed.
- While full, ack is withheld and the strobe simply waits. No data is dropped.
- `full` and `empty` are derived from a registered occupancy count of width `$clog2(DEPTH)+1`. Read and write pointers wrap modulo `DEPTH`.

**Transmitter FSM:** states IDLE, START, DATA, STOP.
- IDLE: if FIFO non-empty, pop the head into a shift register and a `last` flag, then go to START.
- START: drive `o_tx=0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: drive `shift[0]` for `CLKS_PER_BIT` cycles, then shift right. After bit 7, go to STOP.
- STOP: drive `o_tx=1` for `CLKS_PER_BIT` cycles. On the final cycle:
  - If `last`, pulse `o_msg_done`.
  - If FIFO non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- The baud counter resets to 0 on every state change. It counts 0..`CLKS_PER_BIT`-1.
- `o_tx` is registered, so there are no combinational glitches.

**Simultaneous push and pop:** both occur and the count is unchanged. When the FIFO is full, a pop in cycle N frees space that the write sees from cycle N+1.

**Reset mid-frame:** the line returns high immediately (asynchronously). The partial byte and all buffered words are discarded.

## Timing
- Ack latency: strobe seen at edge N, ack high during cycle N+1, low at N+2 even if the strobe persists. Back-to-back writes therefore run at one word per 2 cycles.
- Idle-to-line latency: a word written at edge N is popped at edge N+1 when in IDLE. The start bit begins at N+2.
- Frame: exactly `10*CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- `o_msg_done`: asserted in the cycle after the last stop-bit cycle, width 1.
- `o_empty`: high only when count is 0 and state is IDLE.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3).
  - Frame bit count (10).
  - Flag bit position (8).
- One sub-module, `sync_fifo`:
  - Parameterised width 9 and `DEPTH`.
  - Ports: push, pop, `full`, `empty`, head data.
  - Async active-low reset.
- The UART FSM and ack logic live in the top level.

## Test plan
- **Single flagged byte:** reset, write `0x155` (payload 0x55, flag 1). Expect:
  - Ack one cycle after the strobe.
  - `o_tx` pattern 0,1,0,1,0,1,0,1,0,1 at `CLKS_PER_BIT` spacing.
  - `o_msg_done` pulses once, 1390 cycles after the start bit with default parameters.
- **Backpressure:** write `DEPTH+2` words with the strobe held. Expect:
  - The first `DEPTH+1` ack at 2-cycle spacing (one word goes straight to the transmitter).
  - The next ack is withheld until a stop-bit completion.
  - All bytes emitted in order, none lost.
- **Back-to-back frames:** write 0x041 then 0x142. Expect the second start bit immediately after the first stop bit (no gap), with `o_msg_done` only after 0x42.
- **Read access:** strobe with `we=0`. Expect ack next cycle, `o_empty` stays 1, `o_tx` stays 1.
- **Reset mid-frame:** deassert `i_rst_n` during DATA bit 3. Expect:
  - `o_tx=1` and `o_empty=1` immediately.
  - After release, a new write transmits cleanly.
- **Pointer wrap:** stream `3*DEPTH` sequential bytes 0x00.. with random stb gaps. Expect the decoded UART output to match in order.
